// File: rtl/neuron_sequencer.sv
// Sequences NUM_OUTPUTS saturating Q1.15 dot products over the pixel/weight RAMs into a readback register file.
// Latency: NUM_OUTPUTS*(NUM_INPUTS+2) cycles from start to DONE; RAM data is used one cycle after issue.
// Backpressure: none; one read is issued per RUN cycle and start_calc is a level handshake released in DONE.
module neuron_sequencer #(
    parameter int NUM_INPUTS  = 392,
    parameter int NUM_OUTPUTS = 10
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start_calc,
    input  logic        clear_data,
    input  logic [15:0] pixel_rdata,
    input  logic [31:0] weight_rdata,
    input  logic [3:0]  output_address,
    output logic [9:0]  pixel_raddr,
    output logic [11:0] weight_raddr,
    output logic        mem_ren,
    output logic [16:0] result_output,
    output logic        done_calc,
    output logic        overflow,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, STORE, DONE} state_t;

    localparam logic [9:0] LAST_I = 10'(NUM_INPUTS - 1);
    localparam logic [3:0] LAST_O = 4'(NUM_OUTPUTS - 1);

    state_t             state_q, state_d;
    logic [9:0]         i_q;
    logic [3:0]         o_q;
    logic [11:0]        w_q;
    logic               vld_q;
    logic               ovf_q;
    logic [16:0]        acc_q;
    logic [16:0]        results_q [NUM_OUTPUTS];

    logic signed [15:0] px_s, wt_s;
    logic signed [31:0] product;
    logic signed [16:0] term;
    logic        [17:0] sum;
    logic               sat_hi, sat_lo;
    logic        [16:0] acc_next;
    logic               unused_weight_hi;

    assign unused_weight_hi = ^weight_rdata[31:16];

    // Sum is 18 bits; bits 17 and 16 disagreeing means the 17-bit signed range was left.
    always_comb begin
        px_s     = pixel_rdata;
        wt_s     = weight_rdata[15:0];
        product  = 32'(px_s) * 32'(wt_s);
        term     = 17'(product >>> 15);
        sum      = {acc_q[16], acc_q} + {term[16], term};
        sat_hi   = ~sum[17] & sum[16];
        sat_lo   = sum[17] & ~sum[16];
        acc_next = sat_hi ? 17'h0FFFF : (sat_lo ? 17'h10000 : sum[16:0]);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_calc) state_d = RUN;
            RUN:     if (i_q == LAST_I) state_d = DRAIN;
            DRAIN:   state_d = STORE;
            STORE:   state_d = (o_q == LAST_O) ? DONE : RUN;
            DONE:    if (!start_calc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_data) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!n_rst || clear_data) begin
            state_q <= IDLE;
            i_q     <= '0;
            o_q     <= '0;
            w_q     <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            for (int k = 0; k < NUM_OUTPUTS; k++) results_q[k] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_calc) begin
                        i_q   <= '0;
                        o_q   <= '0;
                        w_q   <= '0;
                        vld_q <= 1'b0;
                        ovf_q <= 1'b0;
                        acc_q <= '0;
                    end
                end
                RUN: begin
                    i_q   <= i_q + 10'd1;
                    w_q   <= w_q + 12'd1;
                    vld_q <= 1'b1;
                    if (vld_q) begin
                        acc_q <= acc_next;
                        if (sat_hi || sat_lo) ovf_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    vld_q <= 1'b0;
                    if (vld_q) begin
                        acc_q <= acc_next;
                        if (sat_hi || sat_lo) ovf_q <= 1'b1;
                    end
                end
                STORE: begin
                    results_q[o_q] <= acc_q;
                    acc_q          <= '0;
                    i_q            <= '0;
                    if (o_q != LAST_O) o_q <= o_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign pixel_raddr   = i_q;
    assign weight_raddr  = w_q;
    assign mem_ren       = (state_q == RUN);
    assign done_calc     = (state_q == DONE);
    assign busy          = (state_q == RUN) || (state_q == DRAIN) || (state_q == STORE);
    assign overflow      = ovf_q;
    assign result_output = (int'(output_address) < NUM_OUTPUTS) ? results_q[output_address] : 17'd0;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer: RAM model, spec-level dot-product scoreboard, address trace and handshake checks.
module tb_neuron_sequencer;

    localparam int NI = 392;
    localparam int NO = 10;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start_calc;
    logic        clear_data;
    logic [15:0] pixel_rdata;
    logic [31:0] weight_rdata;
    logic [3:0]  output_address;
    logic [9:0]  pixel_raddr;
    logic [11:0] weight_raddr;
    logic        mem_ren;
    logic [16:0] result_output;
    logic        done_calc;
    logic        overflow;
    logic        busy;

    logic [15:0] pix_mem [NI];
    logic [31:0] wt_mem  [NI*NO];
    logic [15:0] pix_q, rnd_pix;
    logic [31:0] wt_q, rnd_wt;
    logic        use_rnd;

    logic signed [16:0] exp_res_q [$];
    logic               exp_ovf_q [$];

    int errors = 0;
    int checks = 0;

    neuron_sequencer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start_calc     (start_calc),
        .clear_data     (clear_data),
        .pixel_rdata    (pixel_rdata),
        .weight_rdata   (weight_rdata),
        .output_address (output_address),
        .pixel_raddr    (pixel_raddr),
        .weight_raddr   (weight_raddr),
        .mem_ren        (mem_ren),
        .result_output  (result_output),
        .done_calc      (done_calc),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) begin
            pix_q <= pix_mem[pixel_raddr];
            wt_q  <= wt_mem[weight_raddr];
        end
    end

    assign pixel_rdata  = use_rnd ? rnd_pix : pix_q;
    assign weight_rdata = use_rnd ? rnd_wt  : wt_q;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] px, input logic [15:0] wt);
        for (int i = 0; i < NI; i++) pix_mem[i] = px;
        for (int k = 0; k < NI*NO; k++) wt_mem[k] = {16'($urandom), wt};
    endtask

    // Reference: saturate after every term, term = floor(product / 2^15).
    task automatic push_expected();
        int acc, p, w, prod, term, sum;
        logic signed [15:0] ps, ws;
        logic ovf;
        ovf = 1'b0;
        for (int o = 0; o < NO; o++) begin
            acc = 0;
            for (int i = 0; i < NI; i++) begin
                ps = pix_mem[i];
                ws = wt_mem[o*NI + i][15:0];
                p = ps;
                w = ws;
                prod = p * w;
                term = prod >>> 15;
                sum = acc + term;
                if (sum > 65535) begin acc = 65535; ovf = 1'b1; end
                else if (sum < -65536) begin acc = -65536; ovf = 1'b1; end
                else acc = sum;
            end
            exp_res_q.push_back(17'(acc));
        end
        exp_ovf_q.push_back(ovf);
    endtask

    task automatic check_results(input string tag);
        logic signed [16:0] e;
        for (int a = 0; a < NO; a++) begin
            output_address = 4'(a);
            #1;
            e = exp_res_q.pop_front();
            check($sformatf("%s result[%0d]", tag, a), $signed(result_output), e);
        end
        output_address = 4'd12;
        #1;
        check($sformatf("%s result[12]", tag), $signed(result_output), 0);
        check($sformatf("%s overflow", tag), overflow, exp_ovf_q.pop_front());
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first DONE cycle or of clear_at.
    task automatic run_calc(input int clear_at, input bit pulse, output int done_cyc, output int trace_err);
        int ph;
        logic exp_ren;
        done_cyc  = -1;
        trace_err = 0;
        start_calc = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            @(negedge clk);
            if (cyc == clear_at) begin
                clear_data = 1'b1;
                return;
            end
            if (done_calc) begin
                done_cyc = cyc;
                break;
            end
            start_calc = (pulse && cyc >= 500 && cyc < 600) ? (cyc % 2 == 0) : 1'b1;
            ph = (cyc - 1) % (NI + 2);
            exp_ren = (cyc <= NO*(NI+2)) && (ph < NI);
            if (mem_ren !== exp_ren) trace_err++;
            else if (exp_ren && (pixel_raddr !== 10'(ph) ||
                                 weight_raddr !== 12'(((cyc - 1) / (NI + 2)) * NI + ph))) trace_err++;
            if (busy !== (cyc <= NO*(NI+2))) trace_err++;
        end
    endtask

    task automatic end_run();
        @(negedge clk);
        start_calc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int dc, te, hold_err;
        n_rst = 1'b0;
        use_rnd = 1'b1;
        repeat (2) begin
            start_calc = 1'($urandom);
            clear_data = 1'($urandom);
            rnd_pix = 16'($urandom);
            rnd_wt = $urandom;
            output_address = 4'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        check("rst pixel_raddr", pixel_raddr, 0);
        check("rst weight_raddr", weight_raddr, 0);
        check("rst mem_ren", mem_ren, 0);
        check("rst done_calc", done_calc, 0);
        check("rst overflow", overflow, 0);
        check("rst busy", busy, 0);
        for (int a = 0; a < 16; a++) begin
            output_address = 4'(a);
            #1;
            check($sformatf("rst result[%0d]", a), $signed(result_output), 0);
        end
        @(negedge clk);
        start_calc = 1'b0;
        clear_data = 1'b0;
        use_rnd = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);

        fill(16'h0100, 16'h0100);
        push_expected();
        run_calc(0, 1'b0, dc, te);
        check("basic done cycle", dc, 3941);
        check("basic trace", te, 0);
        check_results("basic");
        end_run();

        fill(16'h0100, 16'h0100);
        for (int i = 0; i < NI; i++) wt_mem[3*NI + i][15:0] = 16'hFF00;
        push_expected();
        run_calc(0, 1'b0, dc, te);
        check("signs done cycle", dc, 3941);
        check("signs trace", te, 0);
        check_results("signs");
        end_run();

        fill(16'h4000, 16'h4000);
        push_expected();
        run_calc(0, 1'b0, dc, te);
        check("satpos trace", te, 0);
        check_results("satpos");
        end_run();

        fill(16'h4000, 16'hC000);
        push_expected();
        run_calc(0, 1'b0, dc, te);
        check("satneg done cycle", dc, 3941);
        check_results("satneg");
        end_run();

        fill(16'h4000, 16'h4000);
        run_calc(2000, 1'b0, dc, te);
        @(negedge clk);
        start_calc = 1'b0;
        check("clear busy", busy, 0);
        check("clear done_calc", done_calc, 0);
        check("clear mem_ren", mem_ren, 0);
        check("clear overflow", overflow, 0);
        for (int a = 0; a < NO; a++) begin
            output_address = 4'(a);
            #1;
            check($sformatf("clear result[%0d]", a), $signed(result_output), 0);
        end
        @(negedge clk);
        clear_data = 1'b0;
        @(negedge clk);
        push_expected();
        run_calc(0, 1'b0, dc, te);
        check("rerun done cycle", dc, 3941);
        check("rerun trace", te, 0);
        check_results("rerun");
        end_run();

        fill(16'h0100, 16'h0100);
        push_expected();
        run_calc(0, 1'b1, dc, te);
        check("pulse done cycle", dc, 3941);
        check("pulse trace", te, 0);
        hold_err = 0;
        repeat (50) begin
            @(negedge clk);
            if (done_calc !== 1'b1 || mem_ren !== 1'b0 || busy !== 1'b0) hold_err++;
        end
        check("hold in done", hold_err, 0);
        check_results("pulse");
        @(negedge clk);
        start_calc = 1'b0;
        check("done before drop", done_calc, 1);
        @(negedge clk);
        check("done after drop", done_calc, 0);
        check("busy after drop", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
